// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master port FSM state type.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_B_WAIT,
        ST_AR_REQ,
        ST_R_WAIT,
        ST_RSP
    } state_e;

endpackage

// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction, one response out.
// Optional watchdog enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master_port
    import axi_lite_pkg::*;
#(
    parameter int ADDR_BW_p        = 12,
    parameter int DATA_BW_p        = 32,
    parameter int TIMEOUT_CYCLES_p = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic                   i_cmd_write,
    input  logic [ADDR_BW_p-1:0]   i_cmd_addr,
    input  logic [DATA_BW_p-1:0]   i_cmd_wdata,
    input  logic [DATA_BW_p/8-1:0] i_cmd_wstrb,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic                   o_rsp_write,
    output logic [DATA_BW_p-1:0]   o_rsp_rdata,
    output logic [1:0]             o_rsp_resp,
    output logic                   o_rsp_timeout,
    output logic [ADDR_BW_p-1:0]   o_axi_awaddr,
    output logic                   o_axi_awvalid,
    input  logic                   i_axi_awready,
    output logic [DATA_BW_p-1:0]   o_axi_wdata,
    output logic [DATA_BW_p/8-1:0] o_axi_wstrb,
    output logic                   o_axi_wvalid,
    input  logic                   i_axi_wready,
    input  logic [1:0]             i_axi_bresp,
    input  logic                   i_axi_bvalid,
    output logic                   o_axi_bready,
    output logic [ADDR_BW_p-1:0]   o_axi_araddr,
    output logic                   o_axi_arvalid,
    input  logic                   i_axi_arready,
    input  logic [DATA_BW_p-1:0]   i_axi_rdata,
    input  logic [1:0]             i_axi_rresp,
    input  logic                   i_axi_rvalid,
    output logic                   o_axi_rready
);

    localparam int STRB_BW = DATA_BW_p / 8;

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 arvalid_q, arvalid_d;
    logic                 bready_q, bready_d;
    logic                 rready_q, rready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 write_q, write_d;
    logic [ADDR_BW_p-1:0] addr_q, addr_d;
    logic [DATA_BW_p-1:0] wdata_q, wdata_d;
    logic [STRB_BW-1:0]   wstrb_q, wstrb_d;
    logic [DATA_BW_p-1:0] rdata_q, rdata_d;
    logic [1:0]           resp_q, resp_d;
    logic                 busy;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES_p > 2) ? $clog2(TIMEOUT_CYCLES_p) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             expired;
`endif

    assign busy = (state_q == ST_WR_REQ) || (state_q == ST_B_WAIT) ||
                  (state_q == ST_AR_REQ) || (state_q == ST_R_WAIT);

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        expired   = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES_p - 1));
        if (busy) cnt_d = cnt_q + 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    write_d = i_cmd_write;
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    wstrb_d = i_cmd_wstrb;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (i_cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_AR_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W channels retire independently, in any order
                if (awvalid_q && i_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && i_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)    state_d   = ST_B_WAIT;
            end
            ST_B_WAIT: begin
                if (i_axi_bvalid) begin
                    resp_d  = i_axi_bresp;
                    rdata_d = '0;
                    state_d = ST_RSP;
                end
            end
            ST_AR_REQ: begin
                if (i_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_R_WAIT;
                end
            end
            ST_R_WAIT: begin
                if (i_axi_rvalid) begin
                    resp_d  = i_axi_rresp;
                    rdata_d = i_axi_rdata;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // Watchdog wins over a same-cycle completion; abandons the bus mid-handshake
        if (expired) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            resp_d    = RESP_SLVERR;
            rdata_d   = '0;
            tmo_d     = 1'b1;
            state_d   = ST_RSP;
        end
`endif
        cmd_ready_d = (state_d == ST_IDLE);
        bready_d    = (state_d == ST_B_WAIT);
        rready_d    = (state_d == ST_R_WAIT);
        rsp_valid_d = (state_d == ST_RSP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign o_rsp_timeout = tmo_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

    assign o_cmd_ready   = cmd_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_write   = write_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_resp    = resp_q;
    assign o_axi_awaddr  = addr_q;
    assign o_axi_awvalid = awvalid_q;
    assign o_axi_wdata   = wdata_q;
    assign o_axi_wstrb   = wstrb_q;
    assign o_axi_wvalid  = wvalid_q;
    assign o_axi_bready  = bready_q;
    assign o_axi_araddr  = addr_q;
    assign o_axi_arvalid = arvalid_q;
    assign o_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Bench for axi_lite_master_port: directed command table against a stall-configurable
// memory slave, plus hand sequences for response back-pressure, reset and the watchdog.
module tb_axi_lite_master_port;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 0, rsp_write, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] o_axi_awaddr, o_axi_araddr;
    logic          o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready;
    logic [DW-1:0] o_axi_wdata;
    logic [SW-1:0] o_axi_wstrb;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    axi_lite_master_port #(.ADDR_BW_p(AW), .DATA_BW_p(DW), .TIMEOUT_CYCLES_p(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
        .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_rsp_timeout(rsp_timeout),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
        .i_axi_wready(wready), .i_axi_bresp(bresp), .i_axi_bvalid(bvalid),
        .o_axi_bready(o_axi_bready), .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid),
        .i_axi_arready(arready), .i_axi_rdata(rdata), .i_axi_rresp(rresp),
        .i_axi_rvalid(rvalid), .o_axi_rready(o_axi_rready)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model (acts on falling edges) ----------------
    int          cfg_awd = 0, cfg_wd = 0, cfg_bd = 0, cfg_ard = 0, cfg_rd = 0;
    logic [1:0]  cfg_resp = 2'b00;
    bit          cfg_ar_never = 0;
    logic [31:0] mem [0:255];
    bit          mem_clr = 0;
    bit          aw_have, w_have, ar_have, b_hs, r_hs;
    int          aw_n, w_n, b_n, ar_n, r_n;
    logic [AW-1:0] aw_a, ar_a, pa_aw, pa_ar;
    logic [DW-1:0] w_d_l, pw_d;
    logic [SW-1:0] w_s_l, pw_s;
    bit          pv_aw, pv_w, pv_ar;
    int          b_cnt = 0, r_cnt = 0, viol = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (!mem_clr) begin
                for (int i = 0; i < 256; i++) mem[i] = 32'h0;
                mem_clr = 1;
            end
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            bresp = 0; rresp = 0; rdata = 0;
            aw_have = 0; w_have = 0; ar_have = 0; b_hs = 0; r_hs = 0;
            aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
            pv_aw = 0; pv_w = 0; pv_ar = 0;
        end else begin
            // a valid left pending at the last edge must still be there, unchanged
            if (pv_aw && (!o_axi_awvalid || o_axi_awaddr !== pa_aw)) viol++;
            if (pv_w && (!o_axi_wvalid || o_axi_wdata !== pw_d || o_axi_wstrb !== pw_s)) viol++;
            if (pv_ar && (!o_axi_arvalid || o_axi_araddr !== pa_ar)) viol++;

            if (awready) begin awready = 0; aw_have = 1; end
            else if (o_axi_awvalid && !aw_have) begin
                if (aw_n >= cfg_awd) begin awready = 1; aw_a = o_axi_awaddr; end else aw_n++;
            end
            if (wready) begin wready = 0; w_have = 1; end
            else if (o_axi_wvalid && !w_have) begin
                if (w_n >= cfg_wd) begin wready = 1; w_d_l = o_axi_wdata; w_s_l = o_axi_wstrb; end
                else w_n++;
            end
            pv_aw = o_axi_awvalid && !awready; pa_aw = o_axi_awaddr;
            pv_w  = o_axi_wvalid && !wready;   pw_d = o_axi_wdata; pw_s = o_axi_wstrb;

            if (b_hs) begin
                bvalid = 0; b_hs = 0; b_cnt++;
                aw_have = 0; w_have = 0; aw_n = 0; w_n = 0; b_n = 0;
            end else if (aw_have && w_have && !bvalid) begin
                if (b_n >= cfg_bd) begin
                    for (int i = 0; i < SW; i++)
                        if (w_s_l[i]) mem[aw_a[9:2]][8*i +: 8] = w_d_l[8*i +: 8];
                    bvalid = 1; bresp = cfg_resp;
                end else b_n++;
            end
            if (o_axi_bready && !(aw_have && w_have)) viol++;
            b_hs = bvalid && o_axi_bready;

            if (arready) begin arready = 0; ar_have = 1; end
            else if (o_axi_arvalid && !ar_have && !cfg_ar_never) begin
                if (ar_n >= cfg_ard) begin arready = 1; ar_a = o_axi_araddr; end else ar_n++;
            end
            pv_ar = o_axi_arvalid && !arready; pa_ar = o_axi_araddr;

            if (r_hs) begin
                rvalid = 0; r_hs = 0; r_cnt++; ar_have = 0; ar_n = 0; r_n = 0;
            end else if (ar_have && !rvalid) begin
                if (r_n >= cfg_rd) begin rvalid = 1; rdata = mem[ar_a[9:2]]; rresp = cfg_resp; end
                else r_n++;
            end
            if (o_axi_rready && !ar_have) viol++;
            r_hs = rvalid && o_axi_rready;
        end
    end

    // ---------------- command side helpers (act 2 time units after rising edge) ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s);
        int k = 0;
        while (!cmd_ready && k < 200) begin step(); k++; end
        check("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        step();
        cmd_valid = 0;
    endtask

    task automatic take_rsp(output logic rw, output logic [DW-1:0] rd, output logic [1:0] rr,
                            output logic rt);
        int k = 0;
        while (!rsp_valid && k < 500) begin step(); k++; end
        check("rsp_valid_wait", rsp_valid, 1'b1);
        rw = rsp_write; rd = rsp_rdata; rr = rsp_resp; rt = rsp_timeout;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        int            awd, wd, bd, ard, rd;
        logic [1:0]    sresp;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          rw, rt;
        logic [DW-1:0] rd;
        logic [1:0]    rr;
        int            b0, r0, bad, k;

        //          wr   addr     data          strb  awd wd bd ard rd sresp  exp_rdata      exp_resp
        vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF,  2'b00};
        vecs[2]  = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,         2'b00};
        vecs[3]  = '{1'b1, 12'h020, 32'h00000012, 4'h1, 0, 0, 0, 0, 0, 2'b00, 32'h0,         2'b00};
        vecs[4]  = '{1'b0, 12'h020, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hFFFFFF12,  2'b00};
        vecs[5]  = '{1'b1, 12'h024, 32'hA5A5A5A5, 4'h6, 3, 0, 2, 0, 0, 2'b00, 32'h0,         2'b00};
        vecs[6]  = '{1'b0, 12'h024, 32'h0,        4'h0, 0, 0, 0, 2, 3, 2'b00, 32'h00A5A500,  2'b00};
        vecs[7]  = '{1'b1, 12'h028, 32'h12345678, 4'hF, 0, 6, 0, 0, 0, 2'b00, 32'h0,         2'b00};
        vecs[8]  = '{1'b0, 12'h028, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h12345678,  2'b00};
        vecs[9]  = '{1'b0, 12'h030, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h0,         2'b11};
        vecs[10] = '{1'b1, 12'h030, 32'h0000BEEF, 4'h3, 0, 0, 0, 0, 0, 2'b10, 32'h0,         2'b10};
        vecs[11] = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF,  2'b01};

        // reset values
        step(); step();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid}, 3'b000);
        check("rst_readies", {o_axi_bready, o_axi_rready}, 2'b00);
        check("rst_rsp", {rsp_valid, rsp_timeout}, 2'b00);
        check("rst_addr_data", {o_axi_awaddr, o_axi_wdata, o_axi_wstrb}, '0);
        rst_n = 1;
        #1 check("post_release_cmd_ready", cmd_ready, 1'b0);
        step();
        check("idle_cmd_ready", cmd_ready, 1'b1);

        foreach (vecs[i]) begin
            cfg_awd = vecs[i].awd; cfg_wd = vecs[i].wd; cfg_bd = vecs[i].bd;
            cfg_ard = vecs[i].ard; cfg_rd = vecs[i].rd; cfg_resp = vecs[i].sresp;
            send_cmd(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].s);
            take_rsp(rw, rd, rr, rt);
            check($sformatf("v%0d_write", i), rw, vecs[i].wr);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_resp", i), rr, vecs[i].exp_resp);
            check($sformatf("v%0d_timeout", i), rt, 1'b0);
        end
        check("b_count", b_cnt, 6);
        check("r_count", r_cnt, 6);
        cfg_awd = 0; cfg_wd = 0; cfg_bd = 0; cfg_ard = 0; cfg_rd = 0; cfg_resp = 2'b00;

        // read issue: ARVALID the cycle after accept, address forwarded, no write channel
        send_cmd(1'b0, 12'h010, '0, '0);
        check("ar_next_cycle", {o_axi_arvalid, o_axi_awvalid, o_axi_wvalid}, 3'b100);
        check("ar_addr", o_axi_araddr, 12'h010);
        check("busy_cmd_ready", cmd_ready, 1'b0);
        take_rsp(rw, rd, rr, rt);
        check("ar_rdata", rd, 32'hDEADBEEF);

        // W stall after AW: exactly one B and one response
        b0 = b_cnt;
        cfg_wd = 6;
        send_cmd(1'b1, 12'h02C, 32'hCAFEF00D, 4'hF);
        step();
        check("wstall_w_pending", {o_axi_awvalid, o_axi_wvalid}, 2'b01);
        take_rsp(rw, rd, rr, rt);
        check("wstall_resp", {rw, rr}, 3'b100);
        check("wstall_one_b", b_cnt - b0, 1);
        check("wstall_no_extra_rsp", rsp_valid, 1'b0);
        cfg_wd = 0;

        // response back-pressure: fields hold, no new command accepted, no AXI traffic
        r0 = r_cnt;
        send_cmd(1'b0, 12'h020, '0, '0);
        k = 0;
        while (!rsp_valid && k < 200) begin step(); k++; end
        check("hold_rsp_valid", rsp_valid, 1'b1);
        rw = rsp_write; rd = rsp_rdata; rr = rsp_resp;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!rsp_valid || rsp_write !== rw || rsp_rdata !== rd || rsp_resp !== rr) bad++;
            if (cmd_ready || o_axi_awvalid || o_axi_wvalid || o_axi_arvalid) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_rdata", rd, 32'hFFFFFF12);
        rsp_ready = 1; step(); rsp_ready = 0;
        check("hold_released", {rsp_valid, cmd_ready}, 2'b01);
        check("hold_one_r", r_cnt - r0, 1);
        check("protocol_violations", viol, 0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // watchdog: ARREADY withheld
        cfg_ar_never = 1;
        send_cmd(1'b0, 12'h040, '0, '0);
        k = 0;
        while (!rsp_valid && k < 100) begin step(); k++; end
        check("to_cycles", k, 16);
        check("to_fields", {rsp_resp, rsp_timeout, rsp_rdata}, {2'b10, 1'b1, 32'h0});
        check("to_bus_idle", {o_axi_arvalid, o_axi_rready}, 2'b00);
        take_rsp(rw, rd, rr, rt);
        cfg_ar_never = 0;
`endif

        // asynchronous reset in the middle of a read data wait
        cfg_rd = 40;
        send_cmd(1'b0, 12'h010, '0, '0);
        step(); step(); step();
        check("mid_rwait_rready", o_axi_rready, 1'b1);
        rst_n = 0;
        #1;
        check("arst_readies", {o_axi_rready, o_axi_bready, cmd_ready}, 3'b000);
        check("arst_valids", {o_axi_arvalid, o_axi_awvalid, o_axi_wvalid, rsp_valid}, 4'b0000);
        check("arst_rsp", {rsp_timeout, rsp_rdata, rsp_resp}, '0);
        cfg_rd = 0;
        step(); step();
        rst_n = 1;
        step();
        send_cmd(1'b0, 12'h010, '0, '0);
        take_rsp(rw, rd, rr, rt);
        check("post_rst_read", {rw, rd, rr, rt}, {1'b0, 32'hDEADBEEF, 2'b00, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
